present_dec80: RTL and testbench

PRESENT_DEC80 -- requirements
Module: present_dec80

---
 rtl/present_dec80.sv | 114 +++++++++++
 tb/tb_present_dec80.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/present_dec80.sv
// present_dec80: iterative PRESENT-80 block decryption, one round per clock
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   start request, sampled only while idle
//   key   80-bit user key (K1, bit 79 = MSB)
//   din   64-bit ciphertext
//   busy  high while a decryption is in progress
//   done  one-cycle pulse when dout becomes valid
//   dout  recovered plaintext, held until overwritten by the next result
// Optional: define PRESENT_DEC_KEYCACHE_EN to cache the last user key and its K32.
module present_dec80 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [79:0] key,
  input  logic [63:0] din,
  output logic        busy,
  output logic        done,
  output logic [63:0] dout
);
  typedef enum logic [1:0] {IDLE, KEYEXP, WHITEN, ROUND} st_t;
  st_t st, st_n;
  logic [79:0] k, k_rot, k_fwd, k_x, k_y, k_inv, k_start;
  logic [63:0] s, s_n;
  logic [4:0] i;
  logic hit;
  function automatic logic [3:0] sb(input logic [3:0] x);
    logic [63:0] t;
    t = 64'h21748FE3DA09B65C;
    return t[{x, 2'b00} +: 4];
  endfunction
  function automatic logic [3:0] isb(input logic [3:0] x);
    logic [63:0] t;
    t = 64'hA970364BD21C8FE5;
    return t[{x, 2'b00} +: 4];
  endfunction
  function automatic logic [63:0] isub(input logic [63:0] x);
    logic [63:0] r;
    for (int n = 0; n < 16; n++) r[4*n +: 4] = isb(x[4*n +: 4]);
    return r;
  endfunction
  // bit P(b) of the input lands on bit b
  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] r;
    for (int b = 0; b < 64; b++) r[b] = x[b == 63 ? 63 : (16 * b) % 63];
    return r;
  endfunction
  assign k_rot = {k[18:0], k[79:19]};
  assign k_fwd = {sb(k_rot[79:76]), k_rot[75:20], k_rot[19:15] ^ i, k_rot[14:0]};
  // k holds K_{i+1}; undo the forward update step by step to get K_i
  assign k_x   = {k[79:20], k[19:15] ^ i, k[14:0]};
  assign k_y   = {isb(k_x[79:76]), k_x[75:0]};
  assign k_inv = {k_y[60:0], k_y[79:61]};
  assign s_n   = isub(ip(s)) ^ k_inv[79:16];
  assign busy  = st != IDLE;
`ifdef PRESENT_DEC_KEYCACHE_EN
  logic cv;
  logic [79:0] ck, ck32;
  assign hit     = cv && key == ck;
  assign k_start = hit ? ck32 : key;
  // the user key is recorded at start; it becomes valid once its K32 exists
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cv   <= 1'b0;
      ck   <= '0;
      ck32 <= '0;
    end else if (st == IDLE && start && !hit) begin
      cv <= 1'b0;
      ck <= key;
    end else if (st == KEYEXP && i == 5'd31) begin
      cv   <= 1'b1;
      ck32 <= k_fwd;
    end
`else
  assign hit     = 1'b0;
  assign k_start = key;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= IDLE;
    else st <= st_n;
  always_comb begin
    st_n = st;
    st_n = st == IDLE   ? (start ? (hit ? WHITEN : KEYEXP) : IDLE) :
           st == KEYEXP ? (i == 5'd31 ? WHITEN : KEYEXP) :
           st == WHITEN ? ROUND :
                          (i == 5'd1 ? IDLE : ROUND);
  end
  // din is parked in the state register until whitening
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      k    <= '0;
      s    <= '0;
      i    <= '0;
      dout <= '0;
      done <= 1'b0;
    end else begin
      done <= st == ROUND && i == 5'd1;
      if (st == IDLE && start) begin
        k <= k_start;
        s <= din;
        i <= hit ? 5'd31 : 5'd1;
      end else if (st == KEYEXP) begin
        k <= k_fwd;
        i <= i == 5'd31 ? i : i + 5'd1;
      end else if (st == WHITEN) begin
        s <= s ^ k[79:16];
      end else if (st == ROUND) begin
        s <= s_n;
        k <= k_inv;
        i <= i - 5'd1;
        if (i == 5'd1) dout <= s_n;
      end
    end
endmodule

// File: tb/tb_present_dec80.sv
// tb_present_dec80: scoreboard bench for present_dec80 using PRESENT-80 reference vectors
module tb_present_dec80;
  logic clk = 0, rst = 1, start = 0, busy, done;
  logic [79:0] key = '0;
  logic [63:0] din = '0, dout;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {logic [63:0] d; int e;} exp_t;
  exp_t q[$];
  localparam logic [79:0] K0 = '0, K1 = '1;
`ifdef PRESENT_DEC_KEYCACHE_EN
  logic m_cv = 0;
  logic [79:0] m_ck = '0;
`endif
  present_dec80 dut (.clk(clk), .rst(rst), .start(start), .key(key), .din(din),
                     .busy(busy), .done(done), .dout(dout));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (!rst && done) begin
      exp_t x;
      checks += 3;
      if (busy) begin
        errors++;
        $display("FAIL busy_at_done: got %b want 0", busy);
      end
      if (q.size() == 0) begin
        errors += 2;
        $display("FAIL unexpected_done: got done at edge %0d want none", cyc);
      end else begin
        x = q.pop_front();
        if (dout !== x.d) begin
          errors++;
          $display("FAIL dout: got %h want %h", dout, x.d);
        end
        if (cyc != x.e) begin
          errors++;
          $display("FAIL latency: got done at edge %0d want %0d", cyc, x.e);
        end
      end
    end
  // called on a falling edge; the start is sampled at the next rising edge
  task automatic issue(input logic [79:0] k, input logic [63:0] d, input logic [63:0] e);
    int lat;
    lat = 63;
`ifdef PRESENT_DEC_KEYCACHE_EN
    if (m_cv && k == m_ck) lat = 32;
    else begin
      m_cv = 1;
      m_ck = k;
    end
`endif
    start = 1;
    key = k;
    din = d;
    q.push_back('{e, cyc + 1 + lat});
    @(negedge clk);
    start = 0;
    key = {$urandom, $urandom, $urandom};
    din = {$urandom, $urandom};
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending results want 0", q.size());
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_wait: got no done want done");
    end
  endtask
  task automatic reset_check(input string tag);
    checks++;
    if (busy !== 0 || done !== 0 || dout !== '0) begin
      errors++;
      $display("FAIL %s: got busy=%b done=%b dout=%h want 0 0 0", tag, busy, done, dout);
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    reset_check("reset_state");
    rst = 0;
    issue(K0, 64'h5579C1387B228445, 64'h0);
    drain();
    issue(K1, 64'hE72C46C0F5945049, 64'h0);
    drain();
    issue(K0, 64'hA112FFC72F68417B, '1);
    wait_done();
    issue(K1, 64'h3333DCD3213210D2, '1);
    drain();
    issue(K1, 64'hE72C46C0F5945049, 64'h0);
    for (int n = 1; n <= 45; n++) begin
      start = n == 5 || n == 20 || n == 40;
      key = {$urandom, $urandom, $urandom};
      din = {$urandom, $urandom};
      if (n == 10) begin
        checks++;
        if (busy !== 1) begin
          errors++;
          $display("FAIL busy_mid: got %b want 1", busy);
        end
      end
      @(negedge clk);
    end
    start = 0;
    drain();
    repeat (70) @(negedge clk);
    issue(K0, 64'h5579C1387B228445, 64'h0);
    repeat (29) @(negedge clk);
    #2 rst = 1;
    #1 reset_check("reset_mid");
    q.delete();
`ifdef PRESENT_DEC_KEYCACHE_EN
    m_cv = 0;
`endif
    @(negedge clk);
    rst = 0;
    issue(K0, 64'hA112FFC72F68417B, '1);
    drain();
    issue(K1, 64'h3333DCD3213210D2, '1);
    drain();
    issue(K0, 64'h5579C1387B228445, 64'h0);
    drain();
    issue(K0, 64'hA112FFC72F68417B, '1);
    drain();
    @(negedge clk);
    rst = 1;
`ifdef PRESENT_DEC_KEYCACHE_EN
    m_cv = 0;
`endif
    @(negedge clk);
    reset_check("reset_again");
    rst = 0;
    issue(K0, 64'h5579C1387B228445, 64'h0);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
